// File: rtl/inst_fetch.sv
// PC generation and fetch queue in front of the instruction cache: issues one PC per cycle,
// replays PCs that missed, and honours redirects. Optional perf counters under INST_FETCH_PERF_EN.
module inst_fetch #(
  parameter int unsigned          WORD_SIZE   = 32,
  parameter int unsigned          QUEUE_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WORD_SIZE-1:0] ptr,
  output logic                 cache_enable,
  input  logic [WORD_SIZE-1:0] cache_inst,
  input  logic                 cache_hit,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [WORD_SIZE-1:0] inst_out,
  output logic [WORD_SIZE-1:0] inst_pc
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]          miss_count,
  output logic [31:0]          stall_count
`endif
);
  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] REPLAY = 2'd2;
  localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(4);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(QUEUE_DEPTH);

  logic [1:0]           state;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] req_pc;
  logic                 inflight;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [AW:0]          count;
  logic [WORD_SIZE-1:0] mem_inst [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0] mem_pc   [QUEUE_DEPTH];
  logic [AW+1:0]        credit_used;
  logic                 credit_ok;
  logic                 miss_now;
  logic                 push;
  logic                 pop;

  // Handshakes: the cache answers every cache_enable exactly one cycle later (hit/out are only
  // meaningful while inflight=1); decode takes the head when inst_valid && inst_ready.
  assign miss_now    = inflight && !cache_hit;
  assign credit_used = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign credit_ok   = credit_used < DEPTH_W;

  assign ptr          = fetch_pc;
  assign cache_enable = (state != BOOT) && !redirect_valid && !miss_now && credit_ok;
  assign inst_valid   = (count != '0) && !redirect_valid;
  assign pop          = inst_valid && inst_ready;
  assign push         = inflight && cache_hit && !redirect_valid;
  assign inst_out     = mem_inst[rd_ptr];
  assign inst_pc      = mem_pc[rd_ptr];

  // Redirect beats a miss, which beats a normal issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      state    <= RUN;
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else if (miss_now) begin
      state    <= REPLAY;
      fetch_pc <= req_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= cache_enable;
      if (cache_enable) begin
        state    <= RUN;
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + PC_STEP;
      end else if (state == BOOT) begin
        state <= RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_inst[wr_ptr] <= cache_inst;
        mem_pc[wr_ptr]   <= req_pc;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Credit accounting guarantees a response always has a free slot.
  always @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && count == (AW+1)'(QUEUE_DEPTH)));
  end

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count  <= '0;
      stall_count <= '0;
    end else begin
      if (miss_now && !redirect_valid && miss_count != '1)
        miss_count <= miss_count + 32'd1;
      if (state != BOOT && !redirect_valid && !miss_now && !credit_ok && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
